instr_fetch_unit: RTL and testbench

Reader side of the program-counter interface. Takes the byte address driven by the program counter, issues a word read to instruction memory over a req/ready handshake, and latches the returned word into the instruction register for the control unit. The control unit starts each fetch with a pulse. The unit reports completion, busy status, and errors for misaligned addresses, out-of-range addresses and memory timeouts.

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: validates pc, reads one word from instruction memory, latches it into ir.
// Latency: 2 cycles start-to-done with zero-wait memory; errors report 1 cycle after start.
// Backpressure: mem_req holds until mem_ready or TIMEOUT cycles; fetch_start is ignored while busy.
module instr_fetch_unit #(
    parameter int          ADDR_W      = 8,
    parameter int          TIMEOUT     = 16,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              fetch_start,
    input  logic [31:0]       pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       ir,
    output logic [31:0]       pc_q,
    output logic              fetch_done,
    output logic              fetch_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       pc_lat, pc_lat_nxt;
    logic              mem_req_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [31:0]       ir_nxt, pc_q_nxt;
    logic              fetch_done_nxt, fetch_err_nxt;
    logic [1:0]        err_code_nxt;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pc_lat_nxt     = pc_lat;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        ir_nxt         = ir;
        pc_q_nxt       = pc_q;
        err_code_nxt   = err_code;
        fetch_done_nxt = 1'b0;
        fetch_err_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fetch_start) begin
                    if (pc[1:0] != 2'b00) begin
                        state_nxt     = S_ERR;
                        err_code_nxt  = 2'd1;
                        fetch_err_nxt = 1'b1;
                    end else if ((pc >> (ADDR_W + 2)) != 32'd0) begin
                        state_nxt     = S_ERR;
                        err_code_nxt  = 2'd2;
                        fetch_err_nxt = 1'b1;
                    end else begin
                        state_nxt    = S_WAIT;
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = pc[ADDR_W+1:2];
                        pc_lat_nxt   = pc;
                        cnt_nxt      = '0;
                    end
                end
            end
            S_WAIT: begin
                // A ready on the final allowed cycle still completes the fetch.
                if (mem_ready) begin
                    state_nxt      = S_DONE;
                    ir_nxt         = mem_rdata;
                    pc_q_nxt       = pc_lat;
                    mem_req_nxt    = 1'b0;
                    err_code_nxt   = 2'd0;
                    fetch_done_nxt = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt     = S_ERR;
                    mem_req_nxt   = 1'b0;
                    err_code_nxt  = 2'd3;
                    fetch_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pc_lat     <= 32'd0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ir         <= RESET_INSTR;
            pc_q       <= 32'd0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            err_code   <= 2'd0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pc_lat     <= pc_lat_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            ir         <= ir_nxt;
            pc_q       <= pc_q_nxt;
            fetch_done <= fetch_done_nxt;
            fetch_err  <= fetch_err_nxt;
            err_code   <= err_code_nxt;
            busy       <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: each fetch is described as a transaction
// (address, memory wait cycles, data) and the expected cycle-by-cycle outcome follows from it.
module tb_instr_fetch_unit;

    localparam int          AW    = 8;
    localparam int          TO    = 16;
    localparam logic [31:0] RST_I = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          fetch_start;
    logic [31:0]   pc;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [31:0]   ir;
    logic [31:0]   pc_q;
    logic          fetch_done;
    logic          fetch_err;
    logic [1:0]    err_code;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;

    // Architectural state expected to persist between fetches
    logic [31:0]   m_ir;
    logic [31:0]   m_pc_q;
    logic [1:0]    m_err;
    logic [AW-1:0] m_addr;

    instr_fetch_unit #(.ADDR_W(AW), .TIMEOUT(TO), .RESET_INSTR(RST_I)) dut (
        .clk(clk), .arst_n(arst_n), .fetch_start(fetch_start), .pc(pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ir(ir), .pc_q(pc_q), .fetch_done(fetch_done), .fetch_err(fetch_err),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"},   32'(mem_req), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_pulse"}, 32'(fetch_done | fetch_err), 32'd0);
        chk({tag, "_ir"},    ir, m_ir);
        chk({tag, "_pcq"},   pc_q, m_pc_q);
        chk({tag, "_code"},  32'(err_code), 32'(m_err));
        chk({tag, "_addr"},  32'(mem_addr), 32'(m_addr));
    endtask

    // Called on the first IDLE cycle; leaves the DUT on the first IDLE cycle afterwards.
    task automatic run_fetch(input logic [31:0] a, input int wt, input logic [31:0] data, input bit noise);
        logic [1:0]    ecode;
        logic [AW-1:0] wa;
        bit            got;
        ecode = (a % 4 != 0) ? 2'd1 : (a >= (32'd1 << (AW + 2))) ? 2'd2 : 2'd0;
        wa    = AW'(a / 4);
        got   = 1'b0;
        pc          = a;
        fetch_start = 1'b1;
        mem_ready   = noise ? 1'($urandom) : 1'b0;
        mem_rdata   = $urandom;
        step();
        fetch_start = 1'b0;
        if (ecode != 2'd0) begin
            chk("err_pulse", 32'(fetch_err), 32'd1);
            chk("err_code",  32'(err_code), 32'(ecode));
            chk("err_noreq", 32'(mem_req), 32'd0);
            chk("err_busy",  32'(busy), 32'd1);
            chk("err_ir",    ir, m_ir);
            chk("err_nodone", 32'(fetch_done), 32'd0);
            m_err = ecode;
        end else begin
            for (int k = 0; k < TO && !got; k++) begin
                chk("wait_req",   32'(mem_req), 32'd1);
                chk("wait_addr",  32'(mem_addr), 32'(wa));
                chk("wait_busy",  32'(busy), 32'd1);
                chk("wait_quiet", 32'(fetch_done | fetch_err), 32'd0);
                mem_ready = (k == wt);
                mem_rdata = (k == wt) ? data : $urandom;
                if (noise) begin
                    pc          = $urandom;
                    fetch_start = 1'($urandom);
                end
                step();
                fetch_start = 1'b0;
                if (k == wt) begin
                    got    = 1'b1;
                    m_ir   = data;
                    m_pc_q = a;
                    m_err  = 2'd0;
                    m_addr = wa;
                    chk("done_pulse", 32'(fetch_done), 32'd1);
                    chk("done_noerr", 32'(fetch_err), 32'd0);
                    chk("done_ir",    ir, m_ir);
                    chk("done_pcq",   pc_q, m_pc_q);
                    chk("done_code",  32'(err_code), 32'd0);
                    chk("done_req",   32'(mem_req), 32'd0);
                    chk("done_busy",  32'(busy), 32'd1);
                end else if (k == TO - 1) begin
                    m_err  = 2'd3;
                    m_addr = wa;
                    chk("to_pulse", 32'(fetch_err), 32'd1);
                    chk("to_code",  32'(err_code), 32'd3);
                    chk("to_req",   32'(mem_req), 32'd0);
                    chk("to_ir",    ir, m_ir);
                    chk("to_pcq",   pc_q, m_pc_q);
                end
            end
        end
        // A start during DONE/ERR must be dropped, not queued
        if (noise) begin
            fetch_start = 1'b1;
            pc          = ($urandom & 32'h0000_03FC);
            mem_ready   = 1'($urandom);
        end
        step();
        fetch_start = 1'b0;
        mem_ready   = 1'b0;
        chk_idle("ret");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          wt;
        arst_n      = 1'b0;
        fetch_start = 1'b0;
        pc          = 32'd0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'd0;
        m_ir   = RST_I;
        m_pc_q = 32'd0;
        m_err  = 2'd0;
        m_addr = '0;
        step();
        step();
        chk_idle("reset");
        chk("reset_done", 32'(fetch_done), 32'd0);
        arst_n = 1'b1;
        step();
        chk_idle("post_reset");

        // Directed cases
        run_fetch(32'h0000_0008, 0, 32'h0010_0093, 1'b0);
        run_fetch(32'h0000_0006, 0, 32'h0, 1'b0);
        run_fetch(32'h0000_0400, 0, 32'h0, 1'b0);
        run_fetch(32'h0000_0024, 3, 32'hDEAD_BEEF, 1'b1);
        run_fetch(32'h0000_0030, TO, 32'h1234_5678, 1'b0);
        run_fetch(32'h0000_0034, TO - 1, 32'hCAFE_F00D, 1'b0);
        run_fetch(32'h0000_03FC, 0, 32'hA5A5_5A5A, 1'b1);
        run_fetch(32'h0000_0003, 0, 32'h0, 1'b1);

        // Reset in the middle of a memory wait, with a sticky error code present
        run_fetch(32'h0000_0401, 0, 32'h0, 1'b0);
        pc          = 32'h0000_0010;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        step();
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        arst_n = 1'b0;
        pc     = $urandom;
        step();
        arst_n = 1'b1;
        m_ir   = RST_I;
        m_pc_q = 32'd0;
        m_err  = 2'd0;
        m_addr = '0;
        chk_idle("mid_rst");
        run_fetch(32'h0000_0010, 1, 32'h0badc0de, 1'b0);

        // Random transactions
        for (int i = 0; i < 160; i++) begin
            case ($urandom % 8)
                0:       a = ($urandom & 32'h0000_03FC) | 32'($urandom_range(1, 3));
                1:       a = (32'd1 << $urandom_range(AW + 2, 31)) | ($urandom & 32'hFFFF_FFFC);
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, (1 << AW) - 1)) << 2;
            endcase
            wt = ($urandom % 4 == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4);
            run_fetch(a, wt, $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
